am_tx_scheduler: RTL and testbench
==================================

// Module: am_tx_scheduler
// PURPOSE
//  Sequences alignment-marker (AM) insertion for the multi-lane TX PCS.
//  Sits between the per-lane scramblers (upstream) and the gearbox (downstream).
//  Counts data blocks and steals one slot per period for the AM, stalling upstream meanwhile.
//  Drives the per-lane insert muxes and BIP accumulators in lockstep across all lanes.
// PARAMETERS
//  LANE_N          4       lanes controlled in lockstep (width of nothing here; doc/assert only)
//  GAP_W           14      width of block counter and period config
//  PERIOD_DEFAULT  16383   data blocks between consecutive AMs after reset
//  CNT_W           16      width of AM sent counter
// PORTS
//  clk             in   1      single clock, all logic on posedge
//  reset           in   1      synchronous, active-high
//  cfg_en_i        in   1      1: insert AMs; 0: pure pass-through
//  cfg_period_i    in   GAP_W  data blocks between AMs; 0 treated as 1
//  cfg_period_we_i in   1      latch cfg_period_i into shadow; applied at next AM
//  up_valid_i      in   1      upstream block (all lanes) available
//  up_ready_o      out  1      upstream block consumed this cycle when up_valid_i&up_ready_o
//  dn_ready_i      in   1      gearbox accepts a slot this cycle
//  dn_valid_o      out  1      slot presented to gearbox
//  marker_v_o      out  1      presented slot is an AM (lane muxes select marker+BIP)
//  bip_clr_o       out  1      AM accepted this cycle: lanes snapshot and clear BIP
//  gap_o           out  GAP_W  data blocks sent since last AM
//  am_cnt_o        out  CNT_W  AMs accepted since reset, wraps
// BEHAVIOUR
//  Reset: state=MARK, gap=0, period_q=shadow=PERIOD_DEFAULT, am_cnt=0; outputs
//   up_ready_o=0, dn_valid_o=1, marker_v_o=1, bip_clr_o=0 (AM first after reset).
//  States (registered, one-hot enum): IDLE, DATA, MARK.
//  IDLE: up_ready_o=dn_ready_i, dn_valid_o=up_valid_i, marker_v_o=0, gap held 0.
//   cfg_en_i=1 -> MARK next cycle.
//  DATA: up_ready_o=dn_ready_i, dn_valid_o=up_valid_i, marker_v_o=0.
//   fire=up_valid_i&dn_ready_i; on fire gap++.
//   fire & gap==eff_period-1 -> MARK, gap<=0 (eff_period = period_q?period_q:1).
//   cfg_en_i=0 -> IDLE, gap<=0 (takes priority over MARK transition; block still passes).
//  MARK: up_ready_o=0, dn_valid_o=1, marker_v_o=1. Held stable until dn_ready_i.
//   dn_ready_i -> bip_clr_o=1 (comb, same cycle), am_cnt++, period_q<=shadow,
//   next = cfg_en_i ? DATA : IDLE. cfg_en_i drop never aborts a presented AM.
//  Zero latency: control outputs are combinational from state and handshake inputs;
//   up_ready_o depends combinationally on dn_ready_i only (no path from up_valid_i).
//  Shadow: cfg_period_we_i loads shadow every cycle it is high; if coincident with
//   AM acceptance, period_q takes cfg_period_i directly (bypass).
//  gap is GAP_W bits; cannot wrap since eff_period<=2^GAP_W-1.
//  dn_ready_i low: nothing advances; gap, state, am_cnt hold.
//  Reset mid-AM or mid-period: immediate return to reset values; next slot is an AM.
//  Assertions: dn_valid_o&marker_v_o&~dn_ready_i stable next cycle; bip_clr_o implies marker_v_o.
// STRUCTURE
//  am_pkg: GAP_W, PERIOD_DEFAULT, state enum typedef am_sched_state_t, lane marker
//   encodings MARKER_LANE0..3 shared with the lane insert modules.
//  One sub-module: am_gap_counter (gap counter, eff_period compare, shadow/period_q
//   registers, bypass); FSM and handshake muxing stay in the top.
// TESTING
//  1 reset, cfg_en=1, up_valid=dn_ready=1 -> cycle0 AM (bip_clr=1), then exactly 16383
//    data fires, AM, repeat; am_cnt_o=3 after 3rd AM.
//  2 period=4 via we, wait one AM -> old period finishes, then AM every 5th slot
//    (4 data + 1 AM); period=0 -> AM every 2nd slot.
//  3 dn_ready random 50% during AM -> marker_v/dn_valid held until accept,
//    up_ready_o=0 throughout, single bip_clr pulse, no data lost/duplicated (scoreboard).
//  4 up_valid bubbles in DATA -> gap_o advances only on fire; AM spacing counts data
//    blocks, not cycles.
//  5 cfg_en 1->0 while AM stalled -> AM completes then IDLE pass-through, gap_o=0;
//    cfg_en 0->1 -> next slot is AM.
//  6 reset asserted with gap_o=2 mid-period -> next cycle state MARK, gap_o=0, am_cnt_o=0.

Source files
------------

// File: rtl/am_tx_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// am_tx_scheduler_pkg
//   Shared constants and types for alignment-marker (AM) insertion in the
//   multi-lane TX PCS. Used by the scheduler, its gap counter, and the
//   per-lane insert modules (lane marker encodings).
// ----------------------------------------------------------------------------
package am_tx_scheduler_pkg;

  localparam int LANE_N = 4;   // lanes driven in lockstep by one scheduler
  localparam int GAP_W  = 14;  // block counter / period config width
  localparam int CNT_W  = 16;  // AM sent counter width

  localparam logic [GAP_W-1:0] PERIOD_DEFAULT = 14'd16383;

  // Per-lane marker bytes M0,M1,M2 (M4..M6 are their bitwise inverses).
  localparam logic [23:0] MARKER_LANE0 = 24'hC1_68_21;
  localparam logic [23:0] MARKER_LANE1 = 24'h9D_71_8E;
  localparam logic [23:0] MARKER_LANE2 = 24'h59_4B_E8;
  localparam logic [23:0] MARKER_LANE3 = 24'h4D_95_7B;

  // One-hot so that each state bit can drive lane muxes directly.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    DATA = 3'b010,
    MARK = 3'b100
  } am_sched_state_t;

  // A programmed period of 0 would never terminate; treat it as 1.
  function automatic logic [GAP_W-1:0] eff_period(input logic [GAP_W-1:0] p);
    return (p == '0) ? GAP_W'(1) : p;
  endfunction

endpackage

// File: rtl/am_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// am_tx_scheduler_if
//   Handshake bundle around the AM scheduler.
//   Upstream (scramblers -> scheduler): up_valid / up_ready.
//   Downstream (scheduler -> gearbox):  dn_valid / dn_ready, plus marker_v
//   (slot is an AM) and bip_clr (AM accepted, lanes snapshot+clear BIP).
//
//   Handshake rule: a transfer happens on a rising clk edge where valid and
//   ready are both high. Once dn_valid is high with marker_v, the slot is held
//   unchanged until dn_ready is seen. Ready never depends on the same side's
//   valid (up_ready is a function of dn_ready and state only).
//
//   master: the scheduler side. slave: the environment (scramblers+gearbox).
// ----------------------------------------------------------------------------
interface am_tx_scheduler_if;
  logic up_valid;
  logic up_ready;
  logic dn_valid;
  logic dn_ready;
  logic marker_v;
  logic bip_clr;

  modport master (
    input  up_valid, dn_ready,
    output up_ready, dn_valid, marker_v, bip_clr
  );

  modport slave (
    output up_valid, dn_ready,
    input  up_ready, dn_valid, marker_v, bip_clr
  );
endinterface

// File: rtl/am_tx_scheduler_gap_counter.sv
// ----------------------------------------------------------------------------
// am_tx_scheduler_gap_counter
//   Counts data blocks since the last AM and flags the final block of the
//   period. Holds the active period (period_q) and a shadow that software
//   writes; the shadow becomes active only when an AM is accepted so that a
//   period change never shortens or stretches the period in flight.
// Ports
//   clk, reset        clock, synchronous active-high reset
//   inc_i             count one data block
//   clr_i             force gap to 0 (has priority over inc_i)
//   accept_i          AM accepted this cycle: period_q <= shadow
//   cfg_period_i      new period value
//   cfg_period_we_i   load shadow (bypassed straight into period_q on accept)
//   gap_o             data blocks since last AM
//   last_o            gap_o == eff_period-1 (next data block ends period)
// ----------------------------------------------------------------------------
module am_tx_scheduler_gap_counter
  import am_tx_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             accept_i,
  input  logic [GAP_W-1:0] cfg_period_i,
  input  logic             cfg_period_we_i,
  output logic [GAP_W-1:0] gap_o,
  output logic             last_o
);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] shadow_q, shadow_d;
  logic [GAP_W-1:0] period_q, period_d;

  always_comb begin
    gap_d    = gap_q;
    shadow_d = shadow_q;
    period_d = period_q;

    if (clr_i)      gap_d = '0;
    else if (inc_i) gap_d = gap_q + GAP_W'(1);

    if (cfg_period_we_i) shadow_d = cfg_period_i;

    // A write landing in the acceptance cycle must not be lost behind the
    // old shadow value.
    if (accept_i) period_d = cfg_period_we_i ? cfg_period_i : shadow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q    <= '0;
      shadow_q <= PERIOD_DEFAULT;
      period_q <= PERIOD_DEFAULT;
    end else begin
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      period_q <= period_d;
    end
  end

  assign gap_o  = gap_q;
  assign last_o = (gap_q == (eff_period(period_q) - GAP_W'(1)));

endmodule

// File: rtl/am_tx_scheduler.sv
// ----------------------------------------------------------------------------
// am_tx_scheduler
//   Sequences alignment-marker insertion for the multi-lane TX PCS. Counts
//   data blocks passed from the scramblers to the gearbox and steals one slot
//   per period for an AM, stalling upstream while the AM is presented. All
//   lanes follow the same marker_v / bip_clr controls.
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   cfg_en_i          1: insert AMs, 0: pure pass-through
//   cfg_period_i      data blocks between AMs (0 treated as 1)
//   cfg_period_we_i   latch cfg_period_i, takes effect at next AM
//   hs                handshake bundle (master side), see am_tx_scheduler_if
//   gap_o             data blocks sent since last AM
//   am_cnt_o          AMs accepted since reset (wraps)
//   state_o           current scheduler state (debug visibility)
// ----------------------------------------------------------------------------
module am_tx_scheduler
  import am_tx_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_en_i,
  input  logic [GAP_W-1:0]      cfg_period_i,
  input  logic                  cfg_period_we_i,
  am_tx_scheduler_if.master     hs,
  output logic [GAP_W-1:0]      gap_o,
  output logic [CNT_W-1:0]      am_cnt_o,
  output am_sched_state_t       state_o
);

  am_sched_state_t  state_q;
  logic             marker_q;
  logic [CNT_W-1:0] am_cnt_q;

  logic in_mark;
  logic in_data;
  logic fire;
  logic am_accept;
  logic last;
  logic gap_inc;
  logic gap_clr;

  assign in_mark = (state_q == MARK);
  assign in_data = (state_q == DATA);
  assign fire    = hs.up_valid & hs.dn_ready;

  // Reset is folded in so that no BIP clear reaches the lanes while the
  // block is being held in reset with the gearbox ready.
  assign am_accept = in_mark & hs.dn_ready & ~reset;

  // Zero-latency handshake muxing. up_ready has no path from up_valid.
  assign hs.up_ready = in_mark ? 1'b0 : hs.dn_ready;
  assign hs.dn_valid = in_mark ? 1'b1 : hs.up_valid;
  assign hs.marker_v = marker_q;
  assign hs.bip_clr  = am_accept;

  // Gap is only live in DATA; every other state (and a disable) parks it at 0.
  assign gap_inc = in_data & fire & cfg_en_i & ~last;
  assign gap_clr = ~in_data | ~cfg_en_i | (fire & last);

  am_tx_scheduler_gap_counter u_gap (
    .clk             (clk),
    .reset           (reset),
    .inc_i           (gap_inc),
    .clr_i           (gap_clr),
    .accept_i        (am_accept),
    .cfg_period_i    (cfg_period_i),
    .cfg_period_we_i (cfg_period_we_i),
    .gap_o           (gap_o),
    .last_o          (last)
  );

  // marker_q is the registered copy of "next state is MARK".
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MARK;
      marker_q <= 1'b1;
      am_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_en_i) begin
            state_q  <= MARK;
            marker_q <= 1'b1;
          end else begin
            marker_q <= 1'b0;
          end
        end
        DATA: begin
          // Disable wins over the period ending; the block still passes.
          if (!cfg_en_i) begin
            state_q  <= IDLE;
            marker_q <= 1'b0;
          end else if (fire && last) begin
            state_q  <= MARK;
            marker_q <= 1'b1;
          end else begin
            marker_q <= 1'b0;
          end
        end
        MARK: begin
          // A presented AM always completes, even if cfg_en_i has dropped.
          if (hs.dn_ready) begin
            am_cnt_q <= am_cnt_q + CNT_W'(1);
            state_q  <= cfg_en_i ? DATA : IDLE;
            marker_q <= 1'b0;
          end else begin
            marker_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= MARK;
          marker_q <= 1'b1;
        end
      endcase
    end
  end

  assign am_cnt_o = am_cnt_q;
  assign state_o  = state_q;

  a_mark_hold: assert property (@(posedge clk) disable iff (reset)
    (hs.dn_valid && hs.marker_v && !hs.dn_ready) |=> (hs.dn_valid && hs.marker_v));

  a_bip_in_mark: assert property (@(posedge clk)
    hs.bip_clr |-> hs.marker_v);

endmodule

// File: tb/tb_am_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_am_tx_scheduler
//   Directed bench for am_tx_scheduler. Inputs change 1 ns after posedge,
//   outputs are checked 2 ns after posedge; the scoreboard samples at negedge.
// ----------------------------------------------------------------------------
module tb_am_tx_scheduler;
  import am_tx_scheduler_pkg::*;

  logic             clk;
  logic             reset;
  logic             cfg_en;
  logic [GAP_W-1:0] cfg_period;
  logic             cfg_period_we;
  logic [GAP_W-1:0] gap;
  logic [CNT_W-1:0] am_cnt;
  am_sched_state_t  state;

  am_tx_scheduler_if hs ();

  am_tx_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_en_i        (cfg_en),
    .cfg_period_i    (cfg_period),
    .cfg_period_we_i (cfg_period_we),
    .hs              (hs.master),
    .gap_o           (gap),
    .am_cnt_o        (am_cnt),
    .state_o         (state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- scoreboard ----------------
  // Every upstream acceptance must appear as exactly one downstream data
  // slot, in order; AM slots carry no upstream data.
  logic [15:0] exp_q[$];
  logic [15:0] up_seq;
  logic [15:0] dn_seq;
  int          bip_cnt;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      up_seq  = '0;
      dn_seq  = '0;
      bip_cnt = 0;
    end else begin
      if (hs.up_valid && hs.up_ready) begin
        exp_q.push_back(up_seq);
        up_seq = up_seq + 16'd1;
      end
      if (hs.dn_valid && hs.dn_ready && !hs.marker_v) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 1);
        else chk("sb_data", 32'(dn_seq), 32'(exp_q.pop_front()));
        dn_seq = dn_seq + 16'd1;
      end
      if (hs.bip_clr) begin
        bip_cnt++;
        chk("bip_implies_marker", 32'(hs.marker_v), 1);
      end
    end
  end

  // Runs cycles with the given up_valid / dn_ready patterns (bit c%8) until
  // an AM is being accepted (bip_clr high, not yet clocked). Counts data fires
  // and tracks the expected gap from the driven handshakes.
  task automatic wait_am(input int budget, input logic [7:0] vpat, input logic [7:0] rpat,
                         input int start_gap, output int n_data, output int n_cyc);
    int gap_m;
    bit stall_prev;
    gap_m      = start_gap;
    stall_prev = 1'b0;
    n_data     = 0;
    n_cyc      = budget;
    for (int c = 0; c < budget; c++) begin
      hs.up_valid = vpat[c % 8];
      hs.dn_ready = rpat[c % 8];
      settle();
      if (stall_prev) chk("am_held", {30'd0, hs.dn_valid, hs.marker_v}, 32'd3);
      if (hs.bip_clr) begin
        n_cyc = c;
        chk("gap_at_am", 32'(gap), 0);
        return;
      end
      if (!hs.marker_v) begin
        chk("gap_track", 32'(gap), 32'(gap_m));
        if (hs.up_valid && hs.dn_ready) begin
          gap_m++;
          n_data++;
        end
      end else begin
        chk("mark_up_ready", 32'(hs.up_ready), 0);
      end
      stall_prev = hs.marker_v && !hs.dn_ready;
      tick();
    end
    chk("am_timeout", 32'(hs.bip_clr), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, ncyc;
    int exp_am;
    exp_am = 0;

    reset         = 1'b1;
    cfg_en        = 1'b1;
    cfg_period    = '0;
    cfg_period_we = 1'b0;
    hs.up_valid   = 1'b1;
    hs.dn_ready   = 1'b1;
    tick();
    tick();

    // Reset state (dn_ready high must not leak a bip_clr)
    settle();
    chk("rst_state",    32'(state), 32'(MARK));
    chk("rst_gap",      32'(gap), 0);
    chk("rst_am_cnt",   32'(am_cnt), 0);
    chk("rst_up_ready", 32'(hs.up_ready), 0);
    chk("rst_dn_valid", 32'(hs.dn_valid), 1);
    chk("rst_marker_v", 32'(hs.marker_v), 1);
    chk("rst_bip_clr",  32'(hs.bip_clr), 0);

    // 1: AM first, then default period of 16383 data blocks
    reset = 1'b0;
    settle();
    chk("t1_first_am_bip", 32'(hs.bip_clr), 1);
    tick(); exp_am++;
    wait_am(16400, 8'hFF, 8'hFF, 0, n, ncyc);
    chk("t1_period_a", 32'(n), 16383);
    tick(); exp_am++;
    wait_am(16400, 8'hFF, 8'hFF, 0, n, ncyc);
    chk("t1_period_b", 32'(n), 16383);
    tick(); exp_am++;
    chk("t1_am_cnt3", 32'(am_cnt), 32'(exp_am));

    // 2: period 4 via shadow; old period finishes first
    cfg_period    = 14'd4;
    cfg_period_we = 1'b1;
    tick();
    cfg_period_we = 1'b0;
    wait_am(16400, 8'hFF, 8'hFF, 1, n, ncyc);
    chk("t2_old_period", 32'(n), 16382);
    tick(); exp_am++;
    wait_am(100, 8'hFF, 8'hFF, 0, n, ncyc);
    chk("t2_p4_a", 32'(n), 4);
    chk("t2_p4_a_slots", 32'(ncyc), 4);
    tick(); exp_am++;
    wait_am(100, 8'hFF, 8'hFF, 0, n, ncyc);
    chk("t2_p4_b", 32'(n), 4);
    // period 0 written in the acceptance cycle (bypass into period_q)
    cfg_period    = 14'd0;
    cfg_period_we = 1'b1;
    settle();
    tick(); exp_am++;
    cfg_period_we = 1'b0;
    wait_am(100, 8'hFF, 8'hFF, 0, n, ncyc);
    chk("t2_p0_a", 32'(n), 1);
    tick(); exp_am++;
    wait_am(100, 8'hFF, 8'hFF, 0, n, ncyc);
    chk("t2_p0_b", 32'(n), 1);
    chk("t2_am_cnt", 32'(am_cnt), 32'(exp_am));

    // 3: gearbox stalls during AMs (ready pattern 1,0,0,1,...)
    for (int k = 0; k < 3; k++) begin
      tick(); exp_am++;
      wait_am(100, 8'hFF, 8'b1000_1001, 0, n, ncyc);
      chk("t3_data_per_am", 32'(n), 1);
      chk("t3_slots", 32'(ncyc), 3);
    end
    chk("t3_am_cnt", 32'(am_cnt), 32'(exp_am));

    // 4: upstream bubbles, period 3: spacing counts blocks not cycles
    cfg_period    = 14'd3;
    cfg_period_we = 1'b1;
    settle();
    tick(); exp_am++;
    cfg_period_we = 1'b0;
    wait_am(100, 8'b1010_0110, 8'hFF, 0, n, ncyc);
    chk("t4_blocks", 32'(n), 3);
    chk("t4_cycles", 32'(ncyc), 6);

    // 5: disable while AM stalled -> AM completes, then IDLE pass-through
    tick(); exp_am++;
    wait_am(100, 8'hFF, 8'hFF, 0, n, ncyc);
    chk("t5_blocks", 32'(n), 3);
    hs.dn_ready = 1'b0;
    cfg_en      = 1'b0;
    settle();
    chk("t5_stall_marker",   32'(hs.marker_v), 1);
    chk("t5_stall_dn_valid", 32'(hs.dn_valid), 1);
    chk("t5_stall_up_ready", 32'(hs.up_ready), 0);
    chk("t5_stall_bip",      32'(hs.bip_clr), 0);
    tick();
    chk("t5_still_mark",     32'(state), 32'(MARK));
    chk("t5_still_marker",   32'(hs.marker_v), 1);
    hs.dn_ready = 1'b1;
    settle();
    chk("t5_accept_bip",     32'(hs.bip_clr), 1);
    tick(); exp_am++;
    chk("t5_idle",           32'(state), 32'(IDLE));
    chk("t5_idle_gap",       32'(gap), 0);
    chk("t5_am_cnt",         32'(am_cnt), 32'(exp_am));
    hs.up_valid = 1'b0;
    settle();
    chk("t5_idle_dn_valid0", 32'(hs.dn_valid), 0);
    chk("t5_idle_marker",    32'(hs.marker_v), 0);
    hs.up_valid = 1'b1;
    hs.dn_ready = 1'b0;
    settle();
    chk("t5_idle_up_ready0", 32'(hs.up_ready), 0);
    chk("t5_idle_dn_valid1", 32'(hs.dn_valid), 1);
    hs.dn_ready = 1'b1;
    settle();
    chk("t5_idle_up_ready1", 32'(hs.up_ready), 1);
    tick();
    chk("t5_idle_gap_held",  32'(gap), 0);
    chk("t5_idle_stays",     32'(state), 32'(IDLE));
    cfg_en = 1'b1;
    settle();
    chk("t5_enable_no_am_yet", 32'(hs.marker_v), 0);
    tick();
    chk("t5_enable_am",      32'(hs.marker_v), 1);
    chk("t5_enable_up_ready", 32'(hs.up_ready), 0);
    chk("t5_enable_bip",     32'(hs.bip_clr), 1);
    tick(); exp_am++;
    // disable on the period's last block: IDLE wins over MARK
    tick();
    tick();
    chk("t5_gap2",           32'(gap), 2);
    cfg_en = 1'b0;
    settle();
    chk("t5_last_passes",    32'(hs.up_ready), 1);
    chk("t5_last_marker",    32'(hs.marker_v), 0);
    tick();
    chk("t5_dis_idle",       32'(state), 32'(IDLE));
    chk("t5_dis_gap",        32'(gap), 0);
    chk("t5_dis_marker",     32'(hs.marker_v), 0);

    // 6: reset mid-period
    cfg_en = 1'b1;
    tick();
    tick(); exp_am++;
    tick();
    tick();
    chk("t6_gap2",           32'(gap), 2);
    chk("t6_am_cnt",         32'(am_cnt), 32'(exp_am));
    reset = 1'b1;
    tick();
    chk("t6_state",          32'(state), 32'(MARK));
    chk("t6_gap",            32'(gap), 0);
    chk("t6_am_cnt0",        32'(am_cnt), 0);
    chk("t6_marker",         32'(hs.marker_v), 1);
    chk("t6_bip_in_reset",   32'(hs.bip_clr), 0);
    reset = 1'b0;
    settle();
    chk("t6_bip",            32'(hs.bip_clr), 1);
    tick();
    chk("t6_am_cnt1",        32'(am_cnt), 1);
    // period must be back at the default after reset
    wait_am(16400, 8'hFF, 8'hFF, 0, n, ncyc);
    chk("t6_default_period", 32'(n), 16383);
    tick();
    chk("t6_am_cnt2",        32'(am_cnt), 2);

    // final scoreboard checks
    chk("sb_empty",          32'(exp_q.size()), 0);
    chk("sb_bip_count",      32'(bip_cnt), 32'(am_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
